// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: upstream push side (in_*), downstream head side (out_*) and forward tap (fwd_*).
// master = the EX/MEM pair driving the stage, slave = the stage itself.
interface ex_mem_stage_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [2:0]        in_op;
    logic [RD_W-1:0]   in_rd;
    logic              in_reg_wr;
    logic              in_mem_rd;
    logic              in_mem_wr;
    logic [DATA_W-1:0] in_st_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_wr;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic [DATA_W-1:0] out_st_data;

    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output in_valid, in_result, in_op, in_rd, in_reg_wr, in_mem_rd, in_mem_wr, in_st_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_zero, out_rd, out_reg_wr, out_mem_rd, out_mem_wr,
        input  out_st_data,
        input  fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  in_valid, in_result, in_op, in_rd, in_reg_wr, in_mem_rd, in_mem_wr, in_st_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_zero, out_rd, out_reg_wr, out_mem_rd, out_mem_wr,
        output out_st_data,
        output fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: DEPTH-entry in-order skid FIFO with registered zero flag and flush.
// Latency 1 cycle push->out_valid, 1 entry/cycle; in_ready drops only when full. Macro EX_MEM_FWD_EN adds forward tap.
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    ex_mem_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [RD_W-1:0]   rd;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic [DATA_W-1:0] st_data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    entry_t             new_entry;
    entry_t             head;

    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Zero flag is only meaningful for compares done as subtract.
    always_comb begin
        new_entry         = '0;
        new_entry.result  = bus.in_result;
        new_entry.zero    = (bus.in_op == 3'b001) && (bus.in_result == '0);
        new_entry.rd      = bus.in_rd;
        new_entry.reg_wr  = bus.in_reg_wr;
        new_entry.mem_rd  = bus.in_mem_rd;
        new_entry.mem_wr  = bus.in_mem_wr;
        new_entry.st_data = bus.in_st_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    assign bus.out_result  = bus.out_valid ? head.result  : '0;
    assign bus.out_zero    = bus.out_valid ? head.zero    : 1'b0;
    assign bus.out_rd      = bus.out_valid ? head.rd      : '0;
    assign bus.out_reg_wr  = bus.out_valid ? head.reg_wr  : 1'b0;
    assign bus.out_mem_rd  = bus.out_valid ? head.mem_rd  : 1'b0;
    assign bus.out_mem_wr  = bus.out_valid ? head.mem_wr  : 1'b0;
    assign bus.out_st_data = bus.out_valid ? head.st_data : '0;

`ifdef EX_MEM_FWD_EN
    // Newest entry is the one most likely needed by the next ALU op; loads have no value yet.
    entry_t tail;
    logic   fwd_hit;

    assign tail          = mem[wr_ptr - PTR_W'(1)];
    assign fwd_hit       = bus.out_valid & tail.reg_wr & ~tail.mem_rd;
    assign bus.fwd_valid = fwd_hit;
    assign bus.fwd_rd    = fwd_hit ? tail.rd     : '0;
    assign bus.fwd_data  = fwd_hit ? tail.result : '0;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = '0;
    assign bus.fwd_data  = '0;
`endif
endmodule
